// File: rtl/pc_control_fsm.sv
// pc_control_fsm: fetch/decode/execute control unit for a 5-bit PC datapath.
// Drives the PC clear/increment strobes and the IR load enable. It also
// decodes the 16-bit instruction into data-memory, register-file and ALU
// controls. Only one instruction is in flight at a time.
//
// Optional build macro PC_CTRL_SINGLE_STEP_EN adds a Step input. With the
// macro defined, FETCH holds until Step=1, so one instruction runs per pulse.
//
// state    | meaning
// ---------+----------------------------------------------------------
// INIT     | PC cleared, nothing else happens
// FETCH    | IR loaded from memory, PC incremented
// DECODE   | opcode inspected, no strobes
// NOOP     | idle execute slot (also reached by unused opcodes)
// LOAD_A   | memory address presented, one cycle of read latency
// LOAD_B   | memory data written into the register file
// STORE    | register A written to data memory
// ADD      | rf[w] <= rf[a] + rf[b]
// SUB      | rf[w] <= rf[a] - rf[b]
// HALT     | parked until reset
module pc_control_fsm #(
  parameter int IR_W = 16,
  parameter int DA_W = 8,
  parameter int RA_W = 4
) (
  input  logic            Clock,
  input  logic            Reset,
`ifdef PC_CTRL_SINGLE_STEP_EN
  input  logic            Step,
`endif
  input  logic [IR_W-1:0] IR,
  output logic            PC_Clr,
  output logic            PC_Up,
  output logic            IR_Ld,
  output logic [DA_W-1:0] D_Addr,
  output logic            D_Wr,
  output logic            RF_s,
  output logic [RA_W-1:0] RF_W_Addr,
  output logic            RF_W_Wr,
  output logic [RA_W-1:0] RF_Ra_Addr,
  output logic [RA_W-1:0] RF_Rb_Addr,
  output logic [2:0]      ALU_s0,
  output logic [3:0]      OutState
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  state_t     state;
  logic [3:0] opcode;
  logic       step_ok;

  // Registered one-hot flags that mirror the state register, so every
  // strobe comes straight from a flop. The async reset clears all write
  // strobes at once.
  logic st_clr;
  logic st_fetch;
  logic st_load;
  logic st_load_wr;
  logic st_store;
  logic st_add;
  logic st_sub;

  assign opcode = IR[IR_W-1 -: 4];

`ifdef PC_CTRL_SINGLE_STEP_EN
  assign step_ok = Step;
`else
  assign step_ok = 1'b1;
`endif

  // State register plus registered per-state flags, all computed from the next state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= S_INIT;
      st_clr     <= 1'b1;
      st_fetch   <= 1'b0;
      st_load    <= 1'b0;
      st_load_wr <= 1'b0;
      st_store   <= 1'b0;
      st_add     <= 1'b0;
      st_sub     <= 1'b0;
    end else begin
      st_clr     <= 1'b0;
      st_fetch   <= 1'b0;
      st_load    <= 1'b0;
      st_load_wr <= 1'b0;
      st_store   <= 1'b0;
      st_add     <= 1'b0;
      st_sub     <= 1'b0;
      case (state)
        S_INIT: begin
          state    <= S_FETCH;
          st_fetch <= 1'b1;
        end
        S_FETCH: begin
          if (step_ok) begin
            state <= S_DECODE;
          end else begin
            state    <= S_FETCH;
            st_fetch <= 1'b1;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_STORE: begin
              state    <= S_STORE;
              st_store <= 1'b1;
            end
            OP_LOAD: begin
              state   <= S_LOAD_A;
              st_load <= 1'b1;
            end
            OP_ADD: begin
              state  <= S_ADD;
              st_add <= 1'b1;
            end
            OP_SUB: begin
              state  <= S_SUB;
              st_sub <= 1'b1;
            end
            OP_HALT: state <= S_HALT;
            OP_NOOP: state <= S_NOOP;
            default: state <= S_NOOP;
          endcase
        end
        S_LOAD_A: begin
          state      <= S_LOAD_B;
          st_load    <= 1'b1;
          st_load_wr <= 1'b1;
        end
        S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: begin
          state    <= S_FETCH;
          st_fetch <= 1'b1;
        end
        S_HALT: state <= S_HALT;
        default: begin
          state  <= S_INIT;
          st_clr <= 1'b1;
        end
      endcase
    end
  end

  // Strobes come from the flags. The address fields are steered from IR
  // according to the instruction format of the current state.
  always_comb begin
    PC_Clr     = st_clr;
    IR_Ld      = st_fetch & step_ok;
    PC_Up      = st_fetch & step_ok;
    D_Wr       = st_store;
    RF_s       = st_load;
    RF_W_Wr    = st_load_wr | st_add | st_sub;
    ALU_s0     = ALU_PASS;
    D_Addr     = '0;
    RF_W_Addr  = '0;
    RF_Ra_Addr = '0;
    RF_Rb_Addr = '0;
    OutState   = state;

    if (st_add)
      ALU_s0 = ALU_ADD;
    else if (st_sub)
      ALU_s0 = ALU_SUB;

    if (st_load) begin
      D_Addr    = IR[11:4];
      RF_W_Addr = IR[3:0];
    end

    if (st_store) begin
      D_Addr     = IR[7:0];
      RF_Ra_Addr = IR[11:8];
    end

    if (st_add | st_sub) begin
      RF_Ra_Addr = IR[11:8];
      RF_Rb_Addr = IR[7:4];
      RF_W_Addr  = IR[3:0];
    end
  end

endmodule

// File: tb/tb_pc_control_fsm.sv
// Testbench for pc_control_fsm. Expected per-cycle outputs are built from
// the instruction table and queued; each test drains its queue cycle by cycle.
module tb_pc_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_clr;
    logic       pc_up;
    logic       ir_ld;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] w_addr;
    logic       w_wr;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
  } outs_t;

  typedef struct packed {
    logic [15:0] ir;
    outs_t       exp;
  } item_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] IR = 16'h0000;
  logic        PC_Clr, PC_Up, IR_Ld, D_Wr, RF_s, RF_W_Wr;
  logic [7:0]  D_Addr;
  logic [3:0]  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, OutState;
  logic [2:0]  ALU_s0;
`ifdef PC_CTRL_SINGLE_STEP_EN
  logic        Step = 1'b1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  item_t sb[$];

  pc_control_fsm dut (
    .Clock(Clock),
    .Reset(Reset),
`ifdef PC_CTRL_SINGLE_STEP_EN
    .Step(Step),
`endif
    .IR(IR),
    .PC_Clr(PC_Clr),
    .PC_Up(PC_Up),
    .IR_Ld(IR_Ld),
    .D_Addr(D_Addr),
    .D_Wr(D_Wr),
    .RF_s(RF_s),
    .RF_W_Addr(RF_W_Addr),
    .RF_W_Wr(RF_W_Wr),
    .RF_Ra_Addr(RF_Ra_Addr),
    .RF_Rb_Addr(RF_Rb_Addr),
    .ALU_s0(ALU_s0),
    .OutState(OutState)
  );

  always #5 Clock = ~Clock;

  // Reference outputs for a state/instruction pair, from the state table.
  function automatic outs_t exp_for(input logic [3:0] st, input logic [15:0] ir);
    outs_t e;
    e = '0;
    e.st = st;
    case (st)
      4'd0: e.pc_clr = 1'b1;
      4'd1: begin e.ir_ld = 1'b1; e.pc_up = 1'b1; end
      4'd4: begin e.d_addr = ir[11:4]; e.w_addr = ir[3:0]; e.rf_s = 1'b1; end
      4'd5: begin e.d_addr = ir[11:4]; e.w_addr = ir[3:0]; e.rf_s = 1'b1; e.w_wr = 1'b1; end
      4'd6: begin e.ra = ir[11:8]; e.d_addr = ir[7:0]; e.d_wr = 1'b1; end
      4'd7: begin e.ra = ir[11:8]; e.rb = ir[7:4]; e.w_addr = ir[3:0]; e.alu = 3'b001; e.w_wr = 1'b1; end
      4'd8: begin e.ra = ir[11:8]; e.rb = ir[7:4]; e.w_addr = ir[3:0]; e.alu = 3'b010; e.w_wr = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.st = OutState; o.pc_clr = PC_Clr; o.pc_up = PC_Up; o.ir_ld = IR_Ld;
    o.d_addr = D_Addr; o.d_wr = D_Wr; o.rf_s = RF_s; o.w_addr = RF_W_Addr;
    o.w_wr = RF_W_Wr; o.ra = RF_Ra_Addr; o.rb = RF_Rb_Addr; o.alu = ALU_s0;
    return o;
  endfunction

  task automatic push(input logic [3:0] st, input logic [15:0] ir);
    item_t it;
    it.ir  = ir;
    it.exp = exp_for(st, ir);
    sb.push_back(it);
  endtask

  // Reset for two clocks, release mid-high-phase so the next negedge is still INIT.
  task automatic do_reset(input logic [15:0] ir);
    IR = ir;
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #2 Reset = 1'b0;
  endtask

  task automatic test_reset();
    outs_t o;
    item_t it;
    IR = 16'h0000;
    Reset = 1'b1;
    @(negedge Clock);
    o = sample();
    n_checks++;
    if (o !== exp_for(4'd0, 16'h0000)) begin
      n_fail++;
      $display("FAIL reset_held got=%h exp=%h", o, exp_for(4'd0, 16'h0000));
    end
    do_reset(16'h0000);
    push(4'd0, 16'h0000); push(4'd1, 16'h0000); push(4'd2, 16'h0000);
    push(4'd3, 16'h0000); push(4'd1, 16'h0000);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(negedge Clock);
      IR = it.ir;
      #1 o = sample();
      n_checks++;
      if (o !== it.exp) begin
        n_fail++;
        $display("FAIL reset_seq got=%h exp=%h", o, it.exp);
      end
    end
  endtask

  task automatic test_add();
    outs_t o;
    item_t it;
    do_reset(16'h3123);
    push(4'd0, 16'h3123); push(4'd1, 16'h3123); push(4'd2, 16'h3123);
    push(4'd7, 16'h3123); push(4'd1, 16'h3123);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(negedge Clock);
      IR = it.ir;
      #1 o = sample();
      n_checks++;
      if (o !== it.exp) begin
        n_fail++;
        $display("FAIL add got=%h exp=%h", o, it.exp);
      end
    end
  endtask

  task automatic test_load();
    outs_t o;
    item_t it;
    do_reset(16'h2A54);
    push(4'd0, 16'h2A54); push(4'd1, 16'h2A54); push(4'd2, 16'h2A54);
    push(4'd4, 16'h2A54); push(4'd5, 16'h2A54); push(4'd1, 16'h2A54);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(negedge Clock);
      IR = it.ir;
      #1 o = sample();
      n_checks++;
      if (o !== it.exp) begin
        n_fail++;
        $display("FAIL load got=%h exp=%h", o, it.exp);
      end
    end
  endtask

  task automatic test_store_sub();
    outs_t o;
    item_t it;
    int    wr_cycles;
    do_reset(16'h17F0);
    push(4'd0, 16'h17F0); push(4'd1, 16'h17F0); push(4'd2, 16'h17F0);
    push(4'd6, 16'h17F0); push(4'd1, 16'h17F0);
    wr_cycles = 0;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(negedge Clock);
      IR = it.ir;
      #1 o = sample();
      if (o.d_wr) wr_cycles++;
      n_checks++;
      if (o !== it.exp) begin
        n_fail++;
        $display("FAIL store got=%h exp=%h", o, it.exp);
      end
    end
    n_checks++;
    if (wr_cycles !== 1) begin
      n_fail++;
      $display("FAIL store_dwr_width got=%0d exp=1", wr_cycles);
    end
    do_reset(16'h4456);
    push(4'd0, 16'h4456); push(4'd1, 16'h4456); push(4'd2, 16'h4456);
    push(4'd8, 16'h4456); push(4'd1, 16'h4456);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(negedge Clock);
      IR = it.ir;
      #1 o = sample();
      n_checks++;
      if (o !== it.exp) begin
        n_fail++;
        $display("FAIL sub got=%h exp=%h", o, it.exp);
      end
    end
  endtask

  task automatic test_halt_illegal();
    outs_t o;
    item_t it;
    do_reset(16'h5000);
    push(4'd0, 16'h5000); push(4'd1, 16'h5000); push(4'd2, 16'h5000);
    for (int i = 0; i < 20; i++) push(4'd9, 16'h5000);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(negedge Clock);
      IR = it.ir;
      #1 o = sample();
      n_checks++;
      if (o !== it.exp) begin
        n_fail++;
        $display("FAIL halt got=%h exp=%h", o, it.exp);
      end
    end
    Reset = 1'b1;
    #1 o = sample();
    n_checks++;
    if (o !== exp_for(4'd0, 16'h5000)) begin
      n_fail++;
      $display("FAIL halt_reset got=%h exp=%h", o, exp_for(4'd0, 16'h5000));
    end
    do_reset(16'hF000);
    push(4'd0, 16'hF000); push(4'd1, 16'hF000); push(4'd2, 16'hF000);
    push(4'd3, 16'hF000); push(4'd1, 16'hF000); push(4'd2, 16'hF000);
    push(4'd3, 16'hF000);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(negedge Clock);
      IR = it.ir;
      #1 o = sample();
      n_checks++;
      if (o !== it.exp) begin
        n_fail++;
        $display("FAIL illegal got=%h exp=%h", o, it.exp);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    outs_t o;
    item_t it;
    do_reset(16'h2A54);
    push(4'd0, 16'h2A54); push(4'd1, 16'h2A54); push(4'd2, 16'h2A54);
    push(4'd4, 16'h2A54);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(negedge Clock);
      IR = it.ir;
      #1 o = sample();
      n_checks++;
      if (o !== it.exp) begin
        n_fail++;
        $display("FAIL midop_pre got=%h exp=%h", o, it.exp);
      end
    end
    // Assert between clock edges: the state must drop without a clock.
    #1 Reset = 1'b1;
    #1 o = sample();
    n_checks++;
    if (o !== exp_for(4'd0, 16'h2A54)) begin
      n_fail++;
      $display("FAIL midop_async got=%h exp=%h", o, exp_for(4'd0, 16'h2A54));
    end
    @(posedge Clock);
    #1 o = sample();
    n_checks++;
    if (o.st !== 4'd0 || o.w_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_held got st=%0d wr=%b exp st=0 wr=0", o.st, o.w_wr);
    end
    do_reset(16'h2A54);
    push(4'd0, 16'h2A54); push(4'd1, 16'h2A54);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(negedge Clock);
      IR = it.ir;
      #1 o = sample();
      n_checks++;
      if (o !== it.exp) begin
        n_fail++;
        $display("FAIL midop_restart got=%h exp=%h", o, it.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    outs_t o;
    item_t it;
    do_reset(16'h3123);
    push(4'd0, 16'h3123); push(4'd1, 16'h3123); push(4'd2, 16'h3123);
    push(4'd7, 16'h3123);
    push(4'd1, 16'h17F0); push(4'd2, 16'h17F0); push(4'd6, 16'h17F0);
    push(4'd1, 16'h2A54); push(4'd2, 16'h2A54); push(4'd4, 16'h2A54);
    push(4'd5, 16'h2A54);
    push(4'd1, 16'h4C9E); push(4'd2, 16'h4C9E); push(4'd8, 16'h4C9E);
    push(4'd1, 16'h5000); push(4'd2, 16'h5000); push(4'd9, 16'h5000);
    push(4'd9, 16'h5000);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(negedge Clock);
      IR = it.ir;
      #1 o = sample();
      n_checks++;
      if (o !== it.exp) begin
        n_fail++;
        $display("FAIL back_to_back got=%h exp=%h", o, it.exp);
      end
      n_checks++;
      if ((o.pc_clr && o.pc_up) || (o.d_wr && o.w_wr)) begin
        n_fail++;
        $display("FAIL exclusivity got clr=%b up=%b dwr=%b wwr=%b exp no overlap",
                 o.pc_clr, o.pc_up, o.d_wr, o.w_wr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_store_sub();
    test_halt_illegal();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
